// File: rtl/mem_access_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM-stage controller
// (master) and the variable-latency data memory (slave).
interface mem_access_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: turns EX/MEM load/store requests into req/ack memory
// transactions, stalls the pipeline until completion and returns load data.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [15:0]       addr,
    input  logic [15:0]       wdata,
    mem_access_ctrl_if.master mem,
    output logic [15:0]       dmem_data,
    output logic              stall,
    output logic              wb_bubble,
    output logic              mem_err,
    output logic [15:0]       acc_count
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_r;
    logic        mem_req_r;
    logic        mem_we_r;
    logic [15:0] mem_addr_r;
    logic [15:0] mem_wdata_r;
    logic [15:0] dmem_data_r;
    logic        mem_err_r;
    logic [15:0] acc_count_r;
    logic [7:0]  tmo_cnt_r;
    logic        access_s;
    logic        stall_s;

    assign access_s = MemRead | MemWrite;

    // Stall while an access is pending in IDLE or in flight in REQ; DONE lets the pipe advance.
    always_comb begin
        stall_s = 1'b0;
        if (state_r == ST_REQ) begin
            stall_s = 1'b1;
        end else if (state_r == ST_IDLE) begin
            stall_s = access_s;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Transaction sequencing, timeout supervision and result/statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 16'h0000;
            mem_wdata_r <= 16'h0000;
            dmem_data_r <= 16'h0000;
            mem_err_r   <= 1'b0;
            acc_count_r <= 16'h0000;
            tmo_cnt_r   <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (access_s) begin
                        // Both flags set is a store; misalignment is flagged but the access goes out aligned.
                        mem_addr_r  <= {addr[15:1], 1'b0};
                        mem_we_r    <= MemWrite;
                        mem_wdata_r <= wdata;
                        mem_req_r   <= 1'b1;
                        tmo_cnt_r   <= 8'd0;
                        state_r     <= ST_REQ;
                        if (addr[0]) begin
                            mem_err_r <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem.mem_ack) begin
                        if (!mem_we_r) begin
                            dmem_data_r <= mem.mem_rdata;
                        end
                        mem_req_r   <= 1'b0;
                        acc_count_r <= acc_count_r + 16'd1;
                        state_r     <= ST_DONE;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        mem_req_r <= 1'b0;
                        mem_err_r <= 1'b1;
                        if (!mem_we_r) begin
                            dmem_data_r <= 16'h0000;
                        end
                        state_r <= ST_DONE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 8'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    mem_req_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem.mem_req   = mem_req_r;
    assign mem.mem_we    = mem_we_r;
    assign mem.mem_addr  = mem_addr_r;
    assign mem.mem_wdata = mem_wdata_r;
    assign dmem_data     = dmem_data_r;
    assign mem_err       = mem_err_r;
    assign acc_count     = acc_count_r;
    assign stall         = stall_s;
    assign wb_bubble     = stall_s;
endmodule
